// File: rtl/sm2201_pkg.sv
// rtl/sm2201_pkg.sv - shared types and constants for the nibble assembler
package sm2201_pkg;

    localparam int NIBBLE_W       = 4;
    localparam int BYTE_W         = 8;
    localparam int SETTLE_CYC_DEF = 2;

    // Acquisition FSM, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEL_LO = 2'd1,
        ST_SEL_HI = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/sm2201_nibble_assembler_if.sv
// rtl/sm2201_nibble_assembler_if.sv - mux-side and ISA-side signal bundle
// master: drives start, q_in, data_ack; observes ws, data_out, data_valid, busy, overrun
// slave : the assembler itself
interface sm2201_nibble_assembler_if;
    import sm2201_pkg::*;

    logic                start;
    logic [NIBBLE_W-1:0] q_in;
    logic                ws;
    logic [BYTE_W-1:0]   data_out;
    logic                data_valid;
    logic                data_ack;
    logic                busy;
    logic                overrun;

    modport master (
        output start, q_in, data_ack,
        input  ws, data_out, data_valid, busy, overrun
    );

    modport slave (
        input  start, q_in, data_ack,
        output ws, data_out, data_valid, busy, overrun
    );
endinterface

// File: rtl/sm2201_settle_timer.sv
// rtl/sm2201_settle_timer.sv - loadable 4-bit settle counter with terminal count
// clk, rst_n : clock, async active-low reset
// load       : load count with load_val (wins over en)
// en         : increment count
// tc         : count equals TERMINAL
module sm2201_settle_timer #(
    parameter logic [3:0] TERMINAL = 4'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       tc
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    assign tc = (count == TERMINAL);

endmodule

// File: rtl/sm2201_nibble_assembler.sv
// rtl/sm2201_nibble_assembler.sv - assembles one byte from two muxed nibbles
// clk, rst_n : clock, async active-low reset
// bus        : slave side of sm2201_nibble_assembler_if
//              start/q_in/data_ack in; ws/data_out/data_valid/busy/overrun out
import sm2201_pkg::*;

module sm2201_nibble_assembler #(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sm2201_nibble_assembler_if.slave   bus
);

    // Count runs 0..SETTLE_CYC-1 in each select state; capture on the last one
    localparam logic [3:0] TC_VAL = 4'(SETTLE_CYC - 1);

    state_t            state_q, state_d;
    logic              ws_q, ws_d;
    logic [BYTE_W-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;
    logic              busy_q, busy_d;
    logic              ovr_q, ovr_d;
    logic              refused;
    logic              tmr_load;
    logic              tmr_en;
    logic              tc;

    // Clearing on every state change gives each state a fresh settle window
    assign tmr_load = (state_d != state_q);
    assign tmr_en   = (state_q == ST_SEL_LO) || (state_q == ST_SEL_HI);

    sm2201_settle_timer #(
        .TERMINAL (TC_VAL)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (4'd0),
        .en       (tmr_en),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ws_q    <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ws_q    <= ws_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        dout_d  = dout_q;
        dv_d    = dv_q;
        ovr_d   = ovr_q;
        refused = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SEL_LO;
                    ws_d    = 1'b0;
                end
            end
            ST_SEL_LO: begin
                refused = bus.start;
                if (tc) begin
                    dout_d[NIBBLE_W-1:0] = bus.q_in;
                    ws_d                 = 1'b1;
                    state_d              = ST_SEL_HI;
                end
            end
            ST_SEL_HI: begin
                refused = bus.start;
                if (tc) begin
                    dout_d[BYTE_W-1:NIBBLE_W] = bus.q_in;
                    dv_d                      = 1'b1;
                    ws_d                      = 1'b0;
                    state_d                   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.data_ack) begin
                    dv_d = 1'b0;
                    // A start alongside the ack is a legal hand-off, so overrun is left alone
                    if (bus.start) begin
                        state_d = ST_SEL_LO;
                    end else begin
                        state_d = ST_IDLE;
                        ovr_d   = 1'b0;
                    end
                end else begin
                    refused = bus.start;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (refused) begin
            ovr_d = 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
    end

    assign bus.ws         = ws_q;
    assign bus.data_out   = dout_q;
    assign bus.data_valid = dv_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_sm2201_nibble_assembler.sv
// tb/tb_sm2201_nibble_assembler.sv - directed self-checking bench for the nibble assembler
import sm2201_pkg::*;

module tb_sm2201_nibble_assembler;

    logic       clk;
    logic       rst_n;
    logic [3:0] lo_src;
    logic [3:0] hi_src;
    int         checks;
    int         failures;

    sm2201_nibble_assembler_if bus_a ();
    sm2201_nibble_assembler_if bus_b ();

    // Upstream mux model: ws picks the nibble source
    assign bus_a.q_in = bus_a.ws ? hi_src : lo_src;
    assign bus_b.q_in = bus_b.ws ? hi_src : lo_src;

    sm2201_nibble_assembler #(.SETTLE_CYC(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    sm2201_nibble_assembler #(.SETTLE_CYC(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n          = 1'b0;
        bus_a.start    = 1'b0;
        bus_a.data_ack = 1'b0;
        bus_b.start    = 1'b0;
        bus_b.data_ack = 1'b0;
        lo_src         = 4'h6;
        hi_src         = 4'h9;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_a.ws, bus_a.data_valid, bus_a.busy, bus_a.overrun} !== 4'b0000) begin
            $display("FAIL reset_a_flags got=%b exp=0000", {bus_a.ws, bus_a.data_valid, bus_a.busy, bus_a.overrun});
            failures++;
        end
        checks++;
        if (bus_a.data_out !== 8'h00) begin
            $display("FAIL reset_a_data got=%h exp=00", bus_a.data_out);
            failures++;
        end
        checks++;
        if ({bus_b.ws, bus_b.data_valid, bus_b.busy, bus_b.overrun, bus_b.data_out} !== 12'h000) begin
            $display("FAIL reset_b got=%h exp=000", {bus_b.ws, bus_b.data_valid, bus_b.busy, bus_b.overrun, bus_b.data_out});
            failures++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // REQ: ws low 2 cycles, high 2 cycles, byte valid 4 edges after start
    task automatic test_basic();
        logic [4:0] exp_ws;
        logic [4:0] exp_dv;
        exp_ws = 5'b01100;
        exp_dv = 5'b10000;
        lo_src = 4'h6;
        hi_src = 4'h9;
        bus_a.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            checks++;
            if (bus_a.ws !== exp_ws[i] || bus_a.data_valid !== exp_dv[i] || bus_a.busy !== 1'b1) begin
                $display("FAIL basic_cycle%0d ws/dv/busy got=%b%b%b exp=%b%b1", i,
                         bus_a.ws, bus_a.data_valid, bus_a.busy, exp_ws[i], exp_dv[i]);
                failures++;
            end
            if (i == 2) begin
                checks++;
                if (bus_a.data_out[3:0] !== 4'h6) begin
                    $display("FAIL basic_lo_nibble got=%h exp=6", bus_a.data_out[3:0]);
                    failures++;
                end
            end
        end
        checks++;
        if (bus_a.data_out !== 8'h96) begin
            $display("FAIL basic_byte got=%h exp=96", bus_a.data_out);
            failures++;
        end
    endtask

    task automatic test_hold_ack();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus_a.data_valid !== 1'b1 || bus_a.data_out !== 8'h96) begin
                $display("FAIL hold_cycle%0d dv/data got=%b/%h exp=1/96", i, bus_a.data_valid, bus_a.data_out);
                failures++;
            end
        end
        bus_a.data_ack = 1'b1;
        @(negedge clk);
        bus_a.data_ack = 1'b0;
        checks++;
        if (bus_a.data_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.data_out !== 8'h96) begin
            $display("FAIL hold_ack dv/busy/data got=%b/%b/%h exp=0/0/96", bus_a.data_valid, bus_a.busy, bus_a.data_out);
            failures++;
        end
        // ack outside HOLD is ignored
        bus_a.data_ack = 1'b1;
        @(negedge clk);
        bus_a.data_ack = 1'b0;
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.data_valid !== 1'b0) begin
            $display("FAIL idle_ack busy/dv got=%b/%b exp=0/0", bus_a.busy, bus_a.data_valid);
            failures++;
        end
    endtask

    task automatic test_overrun();
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (2) @(negedge clk);
        // now in SEL_HI after edge k+2
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.overrun !== 1'b1 || bus_a.ws !== 1'b1) begin
            $display("FAIL overrun_sel_hi ovr/ws got=%b/%b exp=1/1", bus_a.overrun, bus_a.ws);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (bus_a.data_valid !== 1'b1 || bus_a.data_out !== 8'h96) begin
            $display("FAIL overrun_byte dv/data got=%b/%h exp=1/96", bus_a.data_valid, bus_a.data_out);
            failures++;
        end
        bus_a.data_ack = 1'b1;
        @(negedge clk);
        bus_a.data_ack = 1'b0;
        checks++;
        if (bus_a.overrun !== 1'b0 || bus_a.data_valid !== 1'b0) begin
            $display("FAIL overrun_clear ovr/dv got=%b/%b exp=0/0", bus_a.overrun, bus_a.data_valid);
            failures++;
        end
        // start refused in HOLD without ack
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (4) @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.overrun !== 1'b1 || bus_a.data_valid !== 1'b1) begin
            $display("FAIL overrun_hold ovr/dv got=%b/%b exp=1/1", bus_a.overrun, bus_a.data_valid);
            failures++;
        end
        bus_a.data_ack = 1'b1;
        @(negedge clk);
        bus_a.data_ack = 1'b0;
        checks++;
        if (bus_a.overrun !== 1'b0) begin
            $display("FAIL overrun_hold_clear got=%b exp=0", bus_a.overrun);
            failures++;
        end
    endtask

    task automatic test_simultaneous();
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (4) @(negedge clk);
        lo_src = 4'hA;
        hi_src = 4'h5;
        bus_a.start    = 1'b1;
        bus_a.data_ack = 1'b1;
        @(negedge clk);
        bus_a.start    = 1'b0;
        bus_a.data_ack = 1'b0;
        checks++;
        if (bus_a.data_valid !== 1'b0 || bus_a.busy !== 1'b1 || dut_a.state_q !== ST_SEL_LO || bus_a.overrun !== 1'b0) begin
            $display("FAIL simul_handoff dv/busy/state/ovr got=%b/%b/%0d/%b exp=0/1/1/0",
                     bus_a.data_valid, bus_a.busy, dut_a.state_q, bus_a.overrun);
            failures++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus_a.data_out !== 8'h9A || bus_a.ws !== 1'b1) begin
            $display("FAIL simul_lo_only data/ws got=%h/%b exp=9a/1", bus_a.data_out, bus_a.ws);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (bus_a.data_valid !== 1'b0) begin
            $display("FAIL simul_early_valid got=%b exp=0", bus_a.data_valid);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (bus_a.data_valid !== 1'b1 || bus_a.data_out !== 8'h5A || bus_a.overrun !== 1'b0) begin
            $display("FAIL simul_byte dv/data/ovr got=%b/%h/%b exp=1/5a/0", bus_a.data_valid, bus_a.data_out, bus_a.overrun);
            failures++;
        end
        bus_a.data_ack = 1'b1;
        @(negedge clk);
        bus_a.data_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus_a.start = 1'b1;
        @(negedge clk);
        // second start lands in SEL_LO and is refused
        @(negedge clk);
        bus_a.start = 1'b0;
        checks++;
        if (bus_a.overrun !== 1'b1 || dut_a.state_q !== ST_SEL_LO) begin
            $display("FAIL rmid_pre ovr/state got=%b/%0d exp=1/1", bus_a.overrun, dut_a.state_q);
            failures++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.ws, bus_a.data_valid, bus_a.busy, bus_a.overrun, bus_a.data_out} !== 12'h000) begin
            $display("FAIL rmid_async got=%h exp=000", {bus_a.ws, bus_a.data_valid, bus_a.busy, bus_a.overrun, bus_a.data_out});
            failures++;
        end
        @(negedge clk);
        rst_n  = 1'b1;
        lo_src = 4'h6;
        hi_src = 4'h9;
        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus_a.data_valid !== 1'b1 || bus_a.data_out !== 8'h96 || bus_a.overrun !== 1'b0) begin
            $display("FAIL rmid_after dv/data/ovr got=%b/%h/%b exp=1/96/0", bus_a.data_valid, bus_a.data_out, bus_a.overrun);
            failures++;
        end
        bus_a.data_ack = 1'b1;
        @(negedge clk);
        bus_a.data_ack = 1'b0;
    endtask

    task automatic test_settle1();
        logic [2:0] exp_ws;
        logic [2:0] exp_dv;
        exp_ws = 3'b010;
        exp_dv = 3'b100;
        lo_src = 4'h6;
        hi_src = 4'h9;
        bus_b.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            checks++;
            if (bus_b.ws !== exp_ws[i] || bus_b.data_valid !== exp_dv[i]) begin
                $display("FAIL settle1_cycle%0d ws/dv got=%b%b exp=%b%b", i, bus_b.ws, bus_b.data_valid, exp_ws[i], exp_dv[i]);
                failures++;
            end
        end
        checks++;
        if (bus_b.data_out !== 8'h96) begin
            $display("FAIL settle1_byte got=%h exp=96", bus_b.data_out);
            failures++;
        end
        bus_b.data_ack = 1'b1;
        @(negedge clk);
        bus_b.data_ack = 1'b0;
        checks++;
        if (bus_b.data_valid !== 1'b0 || bus_b.busy !== 1'b0) begin
            $display("FAIL settle1_ack dv/busy got=%b/%b exp=0/0", bus_b.data_valid, bus_b.busy);
            failures++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_hold_ack();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
        test_settle1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/sm2201_nibble_assembler.md
SM2201_NIBBLE_ASSEMBLER -- requirements
Module: sm2201_nibble_assembler

Interface
REQ-001 Parameter: SETTLE_CYC, default 2, number of clk cycles ws is held before each nibble capture; legal range 1..15.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to acquire one byte.
REQ-006 q_in  input  4  registered nibble from the upstream 2-input storage mux.
REQ-007 ws  output  1  word select to the upstream mux; 0 selects low-nibble source, 1 selects high-nibble source.
REQ-008 data_out  output  8  assembled byte, {high nibble, low nibble}.
REQ-009 data_valid  output  1  data_out holds a completed byte awaiting ISA read.
REQ-010 data_ack  input  1  ISA-side read strobe; consumes the held byte.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 overrun  output  1  sticky flag; a start was refused.

Function
REQ-013 FSM states: IDLE, SEL_LO, SEL_HI, HOLD; all outputs registered.
REQ-014 IDLE: ws=0, data_valid=0; start=1 at edge k -> SEL_LO, settle counter cleared, ws=0.
REQ-015 SEL_LO: ws=0 for SETTLE_CYC cycles; at edge k+SETTLE_CYC, q_in captured into data_out[3:0], ws set to 1, -> SEL_HI.
REQ-016 SEL_HI: ws=1 for SETTLE_CYC cycles; at edge k+2*SETTLE_CYC, q_in captured into data_out[7:4], data_valid set, ws returned to 0, -> HOLD.
REQ-017 Latency: start accepted at edge k -> data_valid first high after edge k+2*SETTLE_CYC (4 cycles at default).
REQ-018 HOLD: data_out and data_valid stable until data_ack=1; on ack edge data_valid cleared, -> IDLE.
REQ-019 HOLD with data_ack=1 and start=1 in same cycle: ack honoured and start accepted, -> SEL_LO; overrun unchanged.
REQ-020 start=1 in SEL_LO or SEL_HI, or in HOLD without data_ack: request ignored, overrun set to 1, acquisition in progress unaffected.
REQ-021 overrun cleared only by the data_ack edge that consumes the byte, unless a refused start occurs in that same cycle (set wins).
REQ-022 data_ack while not in HOLD: ignored, no state change.
REQ-023 Settle counter 4 bits, saturation not permitted; counter cleared on every state entry.
REQ-024 data_out[3:0] not modified during SEL_HI; data_out holds last byte in IDLE.

Reset
REQ-025 rst_n low asynchronously forces: state IDLE, ws=0, data_out=8'h00, data_valid=0, busy=0, overrun=0, counter=0.
REQ-026 Reset mid-acquisition or in HOLD discards the partial/held byte; first start after rst_n rises is processed normally.

Structure
REQ-027 Shared package sm2201_pkg: FSM state encoding (2 bits), SETTLE_CYC default, nibble/byte width constants.
REQ-028 One sub-module, sm2201_settle_timer: loadable 4-bit counter with terminal-count output, async active-low reset.

Verification
REQ-029 Basic: low source 4'b0110, high source 4'b1001, start pulse at edge k -> ws=0 for 2 cycles, ws=1 for 2 cycles, data_valid at k+4, data_out=8'h96.
REQ-030 Hold/ack: no ack for 20 cycles -> data_out=8'h96 and data_valid stable; ack pulse -> data_valid=0 next cycle, busy=0.
REQ-031 Overrun: start pulse during SEL_HI -> overrun=1, byte still 8'h96; subsequent ack -> overrun=0.
REQ-032 Simultaneous: in HOLD, data_ack and start same cycle -> data_valid=0, state SEL_LO, new byte valid 4 cycles later, overrun=0.
REQ-033 Reset: rst_n low during SEL_LO (asserted asynchronously between edges) -> all outputs at reset values immediately; next start yields correct byte.
REQ-034 SETTLE_CYC=1: start at edge k -> data_valid at k+2 with data_out=8'h96.
